// File: rtl/decode_pipe_stage.sv
// decode_pipe_stage: registered, handshaked MAK-8 instruction-decode stage.
// Decodes each accepted 16-bit instruction into fields and controls held in an
// output register. Provides load-use bubble insertion, flush, sticky halt and a
// saturating hazard stall counter.
// Build option: define DECODE_ILLEGAL_TRAP_EN to flag opcodes 1010-1101 and 1111
// as illegal (id_illegal = 1) and halt on them; otherwise they decode as NOPs.
module decode_pipe_stage #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned PC_W   = 8,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [15:0]       if_instr,
    input  logic [PC_W-1:0]   if_pc,
    input  logic              flush,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [PC_W-1:0]   id_pc,
    output logic [3:0]        id_opcode,
    output logic [2:0]        id_rd,
    output logic [2:0]        id_rs1,
    output logic [2:0]        id_rs2,
    output logic [DATA_W-1:0] id_imm_ext,
    output logic [2:0]        id_branch_cond,
    output logic [2:0]        id_alu_op,
    output logic              id_alu_src,
    output logic              id_reg_write,
    output logic              id_mem_read,
    output logic              id_mem_write,
    output logic              id_mem_to_reg,
    output logic              id_branch,
    output logic              id_jump,
    output logic              id_halt,
    output logic              id_illegal,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [3:0] {
        OP_RTYPE = 4'h0,
        OP_ADDI  = 4'h1,
        OP_SUBI  = 4'h2,
        OP_ANDI  = 4'h3,
        OP_ORI   = 4'h4,
        OP_XORI  = 4'h5,
        OP_LUI   = 4'h6,
        OP_LDB   = 4'h7,
        OP_STB   = 4'h8,
        OP_BR    = 4'h9,
        OP_HLT   = 4'hE
    } opcode_e;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [3:0]        opcode;
        logic [2:0]        rd;
        logic [2:0]        rs1;
        logic [2:0]        rs2;
        logic [DATA_W-1:0] imm;
        logic [2:0]        branch_cond;
        logic [2:0]        alu_op;
        logic              alu_src;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        logic              branch;
        logic              jump;
        logic              halt;
    } dec_t;

    dec_t              dec;
    dec_t              id_q;
    logic              id_valid_q;
    logic              halted_q;
    logic [CNT_W-1:0]  stall_q;
    logic              reads_rs1;
    logic              reads_rs2;
    logic              hazard;
    logic              accept;
    logic              trap;
    logic [DATA_W-1:0] imm_sext;
    logic [2:0]        cond;

    assign imm_sext = DATA_W'($signed(if_instr[5:0]));
    assign cond     = if_instr[11:9];

    // Decode the incoming instruction word and note which registers it reads
    always_comb begin
        dec         = '0;
        reads_rs1   = 1'b0;
        reads_rs2   = 1'b0;
        dec.pc      = if_pc;
        dec.opcode  = if_instr[15:12];
        dec.rd      = if_instr[11:9];
        dec.rs1     = if_instr[8:6];
        case (if_instr[15:12])
            OP_RTYPE: begin
                dec.rs2       = if_instr[5:3];
                dec.reg_write = 1'b1;
                dec.alu_op    = if_instr[2:0];
                reads_rs1     = 1'b1;
                reads_rs2     = 1'b1;
            end
            OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_XORI: begin
                dec.imm       = imm_sext;
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = if_instr[14:12] - 3'd1;
                reads_rs1     = 1'b1;
            end
            OP_LUI: begin
                dec.imm       = imm_sext;
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = 3'b110;
                reads_rs1     = 1'b1;
            end
            OP_LDB: begin
                dec.imm        = imm_sext;
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
                reads_rs1      = 1'b1;
            end
            OP_STB: begin
                // store data register sits in the rd field
                dec.rs2       = if_instr[11:9];
                dec.imm       = imm_sext;
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
                reads_rs1     = 1'b1;
                reads_rs2     = 1'b1;
            end
            OP_BR: begin
                dec.imm         = imm_sext;
                dec.branch_cond = cond;
                dec.branch      = ~cond[2];
                dec.jump        = cond[2];
                dec.reg_write   = (cond == 3'b101);
                reads_rs1       = ~cond[2];
            end
            OP_HLT: begin
                dec.halt = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic illegal_d;
    logic illegal_q;
    assign illegal_d  = (if_instr[15:12] >= 4'hA) && (if_instr[15:12] != 4'hE);
    assign trap       = dec.halt | illegal_d;
    assign id_illegal = illegal_q;

    // Register the illegal flag alongside the decoded instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else if (accept) begin
            illegal_q <= illegal_d;
        end
    end
`else
    assign trap       = dec.halt;
    assign id_illegal = 1'b0;
`endif

    // Load-use: the held load writes a register the incoming instruction reads
    assign hazard = id_valid_q & id_q.mem_read &
                    ((reads_rs1 & (dec.rs1 == id_q.rd)) |
                     (reads_rs2 & (dec.rs2 == id_q.rd)));

    assign if_ready = rst_n & ~halted_q & ~flush & ~hazard & (~id_valid_q | id_ready);
    assign accept   = if_valid & if_ready;

    // Output register: load on accept, drop valid on flush or drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid_q <= 1'b0;
            id_q       <= '0;
        end else if (accept) begin
            id_valid_q <= 1'b1;
            id_q       <= dec;
        end else if (flush || id_ready) begin
            id_valid_q <= 1'b0;
        end
    end

    // Sticky halt, set when a halting instruction is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q <= 1'b0;
        end else if (accept && trap) begin
            halted_q <= 1'b1;
        end
    end

    // Saturating count of cycles a presented instruction is blocked by a hazard
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (if_valid && hazard && (stall_q != '1)) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign id_valid       = id_valid_q;
    assign id_pc          = id_q.pc;
    assign id_opcode      = id_q.opcode;
    assign id_rd          = id_q.rd;
    assign id_rs1         = id_q.rs1;
    assign id_rs2         = id_q.rs2;
    assign id_imm_ext     = id_q.imm;
    assign id_branch_cond = id_q.branch_cond;
    assign id_alu_op      = id_q.alu_op;
    assign id_alu_src     = id_q.alu_src;
    assign id_reg_write   = id_q.reg_write;
    assign id_mem_read    = id_q.mem_read;
    assign id_mem_write   = id_q.mem_write;
    assign id_mem_to_reg  = id_q.mem_to_reg;
    assign id_branch      = id_q.branch;
    assign id_jump        = id_q.jump;
    assign id_halt        = id_q.halt;
    assign halted         = halted_q;
    assign stall_cnt      = stall_q;

endmodule

// File: tb/tb_decode_pipe_stage.sv
// Self-checking bench for decode_pipe_stage: directed test-plan sequences then
// random traffic, with a reference model feeding a scoreboard queue that a
// separate monitor drains on every id_valid & id_ready handshake.
module tb_decode_pipe_stage;

    typedef struct packed {
        logic [7:0]  pc;
        logic [3:0]  opcode;
        logic [2:0]  rd;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic [15:0] imm;
        logic [2:0]  cond;
        logic [2:0]  alu_op;
        logic        alu_src;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        branch;
        logic        jump;
        logic        halt;
        logic        illegal;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_valid = 1'b0;
    logic        if_ready;
    logic [15:0] if_instr = '0;
    logic [7:0]  if_pc = '0;
    logic        flush = 1'b0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [7:0]  id_pc;
    logic [3:0]  id_opcode;
    logic [2:0]  id_rd, id_rs1, id_rs2;
    logic [15:0] id_imm_ext;
    logic [2:0]  id_branch_cond, id_alu_op;
    logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write;
    logic        id_mem_to_reg, id_branch, id_jump, id_halt, id_illegal;
    logic        halted;
    logic [7:0]  stall_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    exp_t       sb[$];
    bit         m_valid;
    exp_t       m_item;
    bit         m_halted;
    int         m_stall;
    logic [7:0] pc_ctr = '0;

    decode_pipe_stage #(.DATA_W(16), .PC_W(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_opcode(id_opcode),
        .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_imm_ext(id_imm_ext),
        .id_branch_cond(id_branch_cond), .id_alu_op(id_alu_op), .id_alu_src(id_alu_src),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch), .id_jump(id_jump),
        .id_halt(id_halt), .id_illegal(id_illegal), .halted(halted), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic exp_t actual_bundle();
        return {id_pc, id_opcode, id_rd, id_rs1, id_rs2, id_imm_ext, id_branch_cond,
                id_alu_op, id_alu_src, id_reg_write, id_mem_read, id_mem_write,
                id_mem_to_reg, id_branch, id_jump, id_halt, id_illegal};
    endfunction

    // Reference decode written from the instruction-set rules
    function automatic exp_t ref_decode(input logic [15:0] w, input logic [7:0] pc);
        exp_t e;
        int op, c, v;
        e = '0;
        op = int'(w[15:12]);
        c  = int'(w[11:9]);
        e.pc = pc; e.opcode = w[15:12]; e.rd = w[11:9]; e.rs1 = w[8:6];
        if (op == 0) e.rs2 = w[5:3];
        else if (op == 8) e.rs2 = w[11:9];
        if (op >= 1 && op <= 9) begin
            v = int'(w[5:0]);
            if (v >= 32) v = v - 64;
            e.imm = 16'(v);
        end
        case (op)
            0: begin e.reg_write = 1; e.alu_op = w[2:0]; end
            1, 2, 3, 4, 5: begin e.reg_write = 1; e.alu_src = 1; e.alu_op = 3'(op - 1); end
            6: begin e.reg_write = 1; e.alu_src = 1; e.alu_op = 3'd6; end
            7: begin e.reg_write = 1; e.alu_src = 1; e.mem_read = 1; e.mem_to_reg = 1; end
            8: begin e.alu_src = 1; e.mem_write = 1; end
            9: begin
                e.cond = w[11:9];
                e.branch = (c < 4);
                e.jump = (c >= 4);
                e.reg_write = (c == 5);
            end
            14: e.halt = 1;
`ifdef DECODE_ILLEGAL_TRAP_EN
            10, 11, 12, 13, 15: e.illegal = 1;
`endif
            default: ;
        endcase
        return e;
    endfunction

    function automatic bit reads_reg(input logic [15:0] w, input logic [2:0] r);
        int op;
        bit src1, src2;
        op = int'(w[15:12]);
        src1 = ((op <= 8) || (op == 9 && w[11:9] < 3'd4)) && (w[8:6] == r);
        src2 = (op == 0 && w[5:3] == r) || (op == 8 && w[11:9] == r);
        return src1 || src2;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every handshake delivers the oldest expected instruction
    always @(negedge clk) begin
        if (rst_n && id_valid && id_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_delivery", 64'(actual_bundle()), 64'hDEAD);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("delivered_instr", 64'(actual_bundle()), 64'(e));
            end
        end
    end

    // One cycle: drive inputs, check state and if_ready, advance the model
    task automatic step(input bit v, input logic [15:0] ins, input bit rdy, input bit fl);
        bit hz, exp_ready, acc;
        exp_t d;
        @(posedge clk); #1;
        if_valid = v; if_instr = ins; if_pc = pc_ctr; id_ready = rdy; flush = fl;
        @(negedge clk);
        check("id_valid", 64'(id_valid), 64'(m_valid));
        check("halted", 64'(halted), 64'(m_halted));
        check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
        hz = m_valid && m_item.mem_read && reads_reg(ins, m_item.rd);
        exp_ready = !m_halted && !fl && !hz && (!m_valid || rdy);
        check("if_ready", 64'(if_ready), 64'(exp_ready));
        acc = v && exp_ready;
        if (v && hz && m_stall < 255) m_stall++;
        if (fl) begin
            if (m_valid) void'(sb.pop_back());
            m_valid = 0;
        end else if (acc) begin
            d = ref_decode(ins, pc_ctr);
            m_valid = 1;
            m_item = d;
            sb.push_back(d);
            if (d.halt || d.illegal) m_halted = 1;
        end else if (rdy) begin
            m_valid = 0;
        end
        pc_ctr++;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 0; if_valid = 0; id_ready = 0; flush = 0;
        @(negedge clk);
        check("rst_if_ready", 64'(if_ready), 64'd0);
        check("rst_id_valid", 64'(id_valid), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        check("rst_id_bundle", 64'(actual_bundle()), 64'd0);
        sb.delete();
        m_valid = 0; m_item = '0; m_halted = 0; m_stall = 0;
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    function automatic logic [15:0] rand_instr();
        int sel;
        logic [3:0] op;
        logic [5:0] lo;
        sel = int'($urandom_range(0, 99));
        if (sel < 25) op = 4'h7;
        else if (sel < 27) op = 4'hE;
        else if (sel < 30) op = 4'($urandom_range(10, 15));
        else op = 4'($urandom_range(0, 9));
        lo = 6'($urandom);
        if (sel % 2 == 0) lo[5:3] = 3'($urandom_range(0, 3));
        return {op, 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), lo};
    endfunction

    initial begin
        int halt_age;
        bit v, rdy, fl;
        m_valid = 0; m_item = '0; m_halted = 0; m_stall = 0;
        do_reset();

        // back-to-back ADDI / XORI
        step(1, 16'h123F, 1, 0);
        step(1, 16'h5245, 1, 0);
        step(0, 16'h0000, 1, 0);
        // load-use: LDB r3 then ADD r4,r3,r2
        step(1, 16'h7642, 1, 0);
        step(1, 16'h08D0, 1, 0);
        step(1, 16'h08D0, 1, 0);
        step(0, 16'h0000, 1, 0);
        check("stall_after_load_use", 64'(stall_cnt), 64'd1);
        // SUBI held under back-pressure
        step(1, 16'h2283, 0, 0);
        step(1, 16'h1041, 0, 0);
        step(1, 16'h1041, 0, 0);
        step(1, 16'h1041, 0, 0);
        step(1, 16'h1041, 1, 0);
        step(0, 16'h0000, 1, 0);
        // flush of a held STB
        step(1, 16'h8A43, 0, 0);
        step(1, 16'h3111, 0, 1);
        step(1, 16'h3111, 0, 0);
        step(0, 16'h0000, 1, 0);
        step(0, 16'h0000, 1, 0);
        // unassigned opcode: trap or NOP depending on build
        step(1, 16'hA000, 1, 0);
        step(1, 16'h123F, 1, 0);
        step(0, 16'h0000, 1, 0);
        do_reset();
        // HLT delivered, then fetch blocked until reset
        step(1, 16'hE000, 1, 0);
        step(1, 16'h123F, 1, 0);
        step(1, 16'h123F, 1, 0);
        step(1, 16'h123F, 1, 0);
        check("halted_after_hlt", 64'(halted), 64'd1);
        do_reset();
        step(1, 16'h123F, 1, 0);
        step(0, 16'h0000, 1, 0);

        // random traffic with periodic recovery from halt
        halt_age = 0;
        for (int i = 0; i < 4000; i++) begin
            v   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            fl  = !rdy && ($urandom_range(0, 9) == 0);
            step(v, rand_instr(), rdy, fl);
            if (m_halted) halt_age++;
            if (halt_age > 6) begin
                do_reset();
                halt_age = 0;
            end
        end

        for (int i = 0; i < 3; i++) step(0, 16'h0000, 1, 0);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_pipe_stage.md
Name: decode_pipe_stage

Overview:
Registered, handshaked instruction-decode stage for the MAK-8 pipeline. It sits between fetch (ROM/PC) and execute. Each accepted 16-bit instruction is decoded into fields and control signals and held in an output register. Adds behaviour the combinational decoder lacks: a valid/ready handshake, load-use hazard bubble insertion, flush, a sticky halt, and a stall counter. The immediate sign-extension width is parametrised.

Parameters:
DATA_W, 16, width of id_imm_ext (must be >= 6)
PC_W, 8, width of the PC carried alongside the instruction
CNT_W, 8, width of the saturating stall counter

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
if_valid  in  1  fetch presents an instruction
if_ready  out  1  stage accepts this cycle (combinational)
if_instr  in  16  instruction word
if_pc  in  PC_W  PC of if_instr
flush  in  1  synchronous kill of the held instruction
id_valid  out  1  decoded instruction valid
id_ready  in  1  execute consumes id_* this cycle
id_pc  out  PC_W  registered PC
id_opcode  out  4  instr[15:12]
id_rd / id_rs1 / id_rs2  out  3 each  register addresses
id_imm_ext  out  DATA_W  sign-extended instr[5:0]
id_branch_cond  out  3  instr[11:9] for opcode 1001, else 0
id_alu_op  out  3  ALU operation
id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch, id_jump, id_halt  out  1 each  control signals
id_illegal  out  1  see Optional Feature
halted  out  1  sticky halt status
stall_cnt  out  CNT_W  hazard stall cycles, saturating

Behaviour:
- Fields:
  - rd = [11:9], rs1 = [8:6].
  - rs2 = [5:3] for R-type (0000); rs2 = rd for STB (1000); 0 otherwise.
  - imm = [5:0] for opcodes 0001–1001, else 0. Sign-extended to DATA_W.
- Controls:
  - 0000: reg_write, alu_op = instr[2:0].
  - 0001–0101: reg_write, alu_src; alu_op = 000/001/010/011/100 (ADD, SUB, AND, OR, XOR).
  - 0110 LUI: reg_write, alu_src, alu_op = 110.
  - 0111 LDB: reg_write, alu_src, mem_read, mem_to_reg, alu_op = 000.
  - 1000 STB: alu_src, mem_write, alu_op = 000.
  - 1001: branch when cond < 100; jump when cond >= 100; reg_write when cond == 101.
  - 1110: halt.
  - All other opcodes: NOP (all controls 0).
- Sources read:
  - R-type reads rs1 and rs2.
  - 0001–0111 read rs1.
  - STB reads rs1 and rd.
  - 1001 with cond < 100 reads rs1.
  - All others read nothing.
- Hazard: hazard = id_valid & id_mem_read & (incoming instruction reads a source equal to id_rd).
- Ready: if_ready = rst_n & ~halted & ~flush & ~hazard & (~id_valid | id_ready).
- Accept: an instruction is accepted when if_valid & if_ready. On accept, the output register loads the decoded fields and pc, and id_valid = 1 on the next edge.
- Drain: id_valid & id_ready with no accept leads to id_valid = 0 next cycle.
- Stall behaviour:
  - A load-use pair yields exactly one bubble. The consumer is held while the load sits in the output register. It is accepted in the cycle after the load leaves, with id_valid = 0 during that cycle.
  - stall_cnt increments each cycle where if_valid & hazard, and saturates at all-ones.
- Flush: id_valid = 0 next edge. No accept occurs in the flush cycle. halted and stall_cnt are unaffected.
- Halt:
  - halted sets on the edge that accepts an HLT. The HLT is still delivered downstream with id_halt = 1.
  - Afterwards if_ready = 0 until reset. halted is cleared only by rst_n.
- Output hold: id_* hold stable while id_valid & ~id_ready.
- Reset: while rst_n = 0, all id_* outputs, halted and stall_cnt = 0 and if_ready = 0. Asserting reset mid-transfer discards the held instruction.
- Latency: 1 cycle from accept to id_valid.
- Throughput: 1 instruction per cycle when there is no hazard and id_ready = 1.

Optional Feature:
DECODE_ILLEGAL_TRAP_EN
- Defined:
  - Opcodes 1010–1101 and 1111 decode with id_illegal = 1 and all other controls 0.
  - Accepting one sets halted exactly as HLT does.
- Undefined:
  - id_illegal is tied to 0.
  - Those opcodes are plain NOPs and do not halt.

Test Plan:
- Reset then back-to-back ADDI r1,r0,#-1 (0x123F), XORI r2,r1,#5 (0x5245) with id_ready = 1 -> id_valid on cycles 1 and 2; id_imm_ext = 0xFFFF then 0x0005; alu_op = 000 then 100; if_ready stays 1.
- LDB r3,r1,#2 (0x7642) followed by ADD r4,r3,r2 using R-type encoding 0x08D0 -> if_ready = 0 while LDB is held; exactly one id_valid = 0 bubble; ADD delivered with rs1 = 3, rs2 = 2; stall_cnt = 1.
- id_ready = 0 for 3 cycles with SUBI held -> id_* stable, if_ready = 0; when id_ready rises, the next instruction is accepted in the same cycle.
- flush asserted while STB 0x8A43 is held and if_valid = 1 -> id_valid = 0 next cycle; the incoming instruction is not accepted that cycle and is accepted the cycle after.
- HLT 0xE000 accepted -> id_halt = 1 delivered; halted = 1; if_ready = 0 despite if_valid; only reset clears halted.
- Macro defined, opcode 0xA000 -> id_illegal = 1, halted = 1. Macro undefined -> NOP with id_illegal = 0 and halted = 0.
